mac_ctrl: RTL
=============

# mac_ctrl

Two-requester arbiter and sequencer for the shared 2-stage multiply-accumulate datapath (mac_2l2h). It accepts RV32M multiply ops and custom accumulate ops from two requesters, such as the decode pipe and a coprocessor port. It sign-extends operands to 33 bits and drives the MAC's one-cycle command strobes. It captures the MAC result and returns it to the owning requester with a valid/ready handshake. It also tracks which requester owns the MAC's internal accumulator.

## Interface
- RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, requester 0 first.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- pause  in  1  global pipeline stall; passed through to the MAC
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; at most one bit set, for one cycle
- req_op  in  6  3 bits per requester ([2:0] req0): 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MACL, 5 MACH, 6/7 illegal
- req_a, req_b  in  64  32-bit operands per requester ([31:0] req0)
- rsp_valid  out  2  response valid, one-hot to the granted requester
- rsp_ready  in  2  per-requester response accept
- rsp_data  out  32  result
- rsp_err  out  1  response is an error (data 0)
- mac_mul_en, mac_low, mac_high  out  1 each  MAC command strobes
- mac_din1, mac_din2  out  33 each  sign-extended operands
- mac_pause  out  1  equals pause
- mac_dlout, mac_dhout  in  32 each  MAC results
- mac_vldout, mac_vhdout  in  1 each  MAC result valids

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE, arbitration:**
  - Arbitration runs only when pause=0 and no response is pending.
  - When both requesters are valid, round-robin grants the requester that was not granted last. last_grant resets to 1, so requester 0 wins first.
  - On grant: req_ready[g]=1 for that cycle; op and operands are latched; g is stored.
- **Op decode (legal ops → ISSUE):**
  - op0: mul_en=1, mac_low=1.
  - op1–3: mul_en=1, mac_high=1.
  - op4: mul_en=0, mac_low=1.
  - op5: mul_en=0, mac_high=1.
- **Sign extension:**
  - din1[32] = a[31] for ops 0, 1, 2, 4, 5; otherwise 0.
  - din2[32] = b[31] for ops 0, 1, 4, 5; otherwise 0.
- **Accumulator ownership:**
  - acc_vld and acc_own are set to {1, g} when an op 0–3 issues.
  - An op 4/5 from g is legal only if acc_vld=1 and acc_own=g.
- **Rejections:** an op 4/5 from a non-owner, or any op 6/7, skips the datapath. The FSM goes directly IDLE→RESP with rsp_err=1, rsp_data=0, and ownership unchanged.
- **ISSUE:** the strobes are high for exactly one cycle with pause=0. While pause=1 they are held low and the FSM stays in ISSUE. Next state is WAIT.
- **WAIT:** on mac_vldout (low ops) or mac_vhdout (high ops), capture mac_dlout or mac_dhout, respectively, into the response register and go to RESP. While pause=1, the FSM stays in WAIT (the MAC gates its valids during pause).
- **RESP:** rsp_valid[g]=1 and data stay stable until rsp_ready[g]=1, then return to IDLE. RESP ignores pause.
- **Single op in flight:** no new grant is made while not in IDLE.

## Timing
- Reset (asynchronous) forces:
  - state IDLE;
  - every output to 0, including req_ready, rsp_valid, rsp_data, rsp_err, strobes, and din;
  - acc_vld=0, last_grant=1.
- Legal op, no pause: grant at T, strobes at T+1, MAC valid and capture at T+2, rsp_valid from T+3. The earliest next grant is the cycle after rsp_ready.
- Rejected op: grant at T, rsp_valid from T+1.
- Each pause cycle in ISSUE or WAIT adds one cycle of latency.
- A grant and a response handshake never occur in the same cycle.
- Reset mid-op drops the in-flight op (no response) and clears ownership.
- A MAC valid of the wrong kind in WAIT (vhdout for a low op, or vldout for a high op) is ignored.
- rsp_ready on the non-granted requester is ignored.

## Test plan
- MUL from req0 with a=0xFFFFFFFF, b=2 → strobes mul_en=1, mac_low=1 at T+1; rsp_data=0xFFFFFFFE at T+3 with rsp_err=0.
- MULHU, MULH, MULHSU with a=b=0xFFFFFFFF → rsp_data 0xFFFFFFFE, 0x00000000, 0xFFFFFFFF respectively. Check mac_din1/mac_din2 bit 32 for each.
- req0 MUL 3×4, then MACL 5×6 → responses 12, then 42. A req1 MACL afterwards → rsp_err=1, data 0, no MAC strobes, and req0 still owns the accumulator.
- Both requesters valid continuously, RR_EN=1 → grants 0,1,0,1; with RR_EN=0 → grants 0,0,0.
- pause high for 3 cycles during ISSUE, then 2 cycles during WAIT → result is correct and rsp_valid is delayed by 5 cycles. rsp_ready held low for 4 cycles → data stable and no new grant.
- Reset asserted in WAIT → all outputs 0 immediately, no response; a subsequent MACL → rsp_err=1. Op 7 → rsp_err=1 at T+1.

Source files
------------

// File: rtl/mac_ctrl_if.sv
// Requester/response and MAC command bundle for mac_ctrl.
// Ports: pause, req_*, rsp_*, mac_* (slave = controller, master = env).
interface mac_ctrl_if;
   logic        pause;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [5:0]  req_op;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        mac_mul_en;
   logic        mac_low;
   logic        mac_high;
   logic [32:0] mac_din1;
   logic [32:0] mac_din2;
   logic        mac_pause;
   logic [31:0] mac_dlout;
   logic [31:0] mac_dhout;
   logic        mac_vldout;
   logic        mac_vhdout;

   modport slave (
      input  pause, req_valid, req_op, req_a, req_b, rsp_ready,
      input  mac_dlout, mac_dhout, mac_vldout, mac_vhdout,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output mac_mul_en, mac_low, mac_high,
      output mac_din1, mac_din2, mac_pause
   );

   modport master (
      output pause, req_valid, req_op, req_a, req_b, rsp_ready,
      output mac_dlout, mac_dhout, mac_vldout, mac_vhdout,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  mac_mul_en, mac_low, mac_high,
      input  mac_din1, mac_din2, mac_pause
   );
endinterface

// File: rtl/mac_ctrl.sv
// Two-requester arbiter/sequencer for the shared 2-stage MAC datapath.
// Ports: clk, reset (async, active-high), bus (mac_ctrl_if.slave).
module mac_ctrl #(
   parameter bit RR_EN = 1'b1
) (
   input logic       clk,
   input logic       reset,
   mac_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE, ISSUE, WAIT, RESP
   } state_e;

   state_e      state_q, state_d;
   logic        gnt_q, gnt_d;
   logic        last_q, last_d;
   logic        acc_vld_q, acc_vld_d;
   logic        acc_own_q, acc_own_d;
   logic        err_q, err_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] data_q, data_d;

   logic        pick;
   logic        legal;
   logic [2:0]  op_in;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        op_mul;
   logic        op_low;
   logic        sx_a;
   logic        sx_b;

   always_comb begin
      pick = bus.req_valid[1];
      if (&bus.req_valid)
         pick = RR_EN ? ~last_q : 1'b0;
   end

   assign op_in = pick ? bus.req_op[5:3] : bus.req_op[2:0];
   assign a_in  = pick ? bus.req_a[63:32] : bus.req_a[31:0];
   assign b_in  = pick ? bus.req_b[63:32] : bus.req_b[31:0];

   // 0-3 always legal; 4/5 only for the accumulator owner; 6/7 never
   assign legal = ~op_in[2]
                | (~op_in[1] & acc_vld_q & (acc_own_q == pick));

   assign op_mul = ~op_q[2];
   assign op_low = (op_q[1:0] == 2'b00);
   assign sx_a   = a_q[31] & (op_q inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
   assign sx_b   = b_q[31] & (op_q inside {3'd0, 3'd1, 3'd4, 3'd5});

   assign bus.mac_din1  = {sx_a, a_q};
   assign bus.mac_din2  = {sx_b, b_q};
   assign bus.mac_pause = bus.pause;
   assign bus.rsp_data  = data_q;
   assign bus.rsp_err   = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
         acc_vld_q <= 1'b0;
         acc_own_q <= 1'b0;
         err_q     <= 1'b0;
         op_q      <= 3'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         data_q    <= 32'd0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         acc_vld_q <= acc_vld_d;
         acc_own_q <= acc_own_d;
         err_q     <= err_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         data_q    <= data_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      gnt_d          = gnt_q;
      last_d         = last_q;
      acc_vld_d      = acc_vld_q;
      acc_own_d      = acc_own_q;
      err_d          = err_q;
      op_d           = op_q;
      a_d            = a_q;
      b_d            = b_q;
      data_d         = data_q;
      bus.req_ready  = 2'b00;
      bus.rsp_valid  = 2'b00;
      bus.mac_mul_en = 1'b0;
      bus.mac_low    = 1'b0;
      bus.mac_high   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // gated by reset so req_ready is 0 while reset is held
            if (!reset && !bus.pause && |bus.req_valid) begin
               bus.req_ready = pick ? 2'b10 : 2'b01;
               gnt_d  = pick;
               last_d = pick;
               op_d   = op_in;
               a_d    = a_in;
               b_d    = b_in;
               if (legal) begin
                  err_d   = 1'b0;
                  state_d = ISSUE;
               end else begin
                  err_d   = 1'b1;
                  data_d  = 32'd0;
                  state_d = RESP;
               end
            end
         end
         ISSUE: begin
            if (!bus.pause) begin
               bus.mac_mul_en = op_mul;
               bus.mac_low    = op_low;
               bus.mac_high   = ~op_low;
               state_d        = WAIT;
               if (op_mul) begin
                  acc_vld_d = 1'b1;
                  acc_own_d = gnt_q;
               end
            end
         end
         WAIT: begin
            // only the valid matching the op kind completes it
            if (!bus.pause) begin
               if (op_low && bus.mac_vldout) begin
                  data_d  = bus.mac_dlout;
                  state_d = RESP;
               end else if (!op_low && bus.mac_vhdout) begin
                  data_d  = bus.mac_dhout;
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            bus.rsp_valid = gnt_q ? 2'b10 : 2'b01;
            if (bus.rsp_ready[gnt_q])
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
